// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand bypass select plus per-register latency scoreboard for load/multi-cycle stalls.
// Define HAZARD_PERF_EN to build the saturating stall_cycles performance counter.
module hazard_forward_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_SRC*ADDR_W-1:0] Raddr_D,
  input  logic [NUM_SRC-1:0]        Rused_D,
  input  logic [NUM_SRC*ADDR_W-1:0] Raddr_E,
  input  logic                      issue_E,
  input  logic [ADDR_W-1:0]         Waddr_E,
  input  logic [LAT_W-1:0]          lat_E,
  input  logic [ADDR_W-1:0]         Waddr_M,
  input  logic                      RegWrite_M,
  input  logic [ADDR_W-1:0]         Waddr_W,
  input  logic                      RegWrite_W,
  output logic [2*NUM_SRC-1:0]      forward,
  output logic                      stall_D,
  output logic                      bubble_E,
  output logic                      busy,
  output logic [31:0]               stall_cycles
);
  localparam int NREG = 1 << ADDR_W;
  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] dec [NREG];
  logic [LAT_W-1:0] nxt [NREG];
  logic [NREG-1:0]  nz;
  always_comb begin
    nz = '0;
    for (int r = 0; r < NREG; r++) begin
      dec[r] = (cnt[r] == '0) ? '0 : cnt[r] - LAT_W'(1);
      nxt[r] = (r != 0 && issue_E && Waddr_E == ADDR_W'(r) && lat_E > dec[r]) ? lat_E : dec[r];
      nz[r]  = cnt[r] != '0;
    end
  end
  // x0 is kept at zero so reads of it never stall
  always_ff @(posedge clk)
    for (int r = 0; r < NREG; r++)
      if (rst || r == 0) cnt[r] <= '0;
      else if (!hold) cnt[r] <= nxt[r];
  always_comb begin
    stall_D = 1'b0;
    forward = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      stall_D = stall_D | (Rused_D[s] && Raddr_D[s*ADDR_W +: ADDR_W] != '0 &&
                (cnt[Raddr_D[s*ADDR_W +: ADDR_W]] > LAT_W'(1) ||
                 (issue_E && Waddr_E == Raddr_D[s*ADDR_W +: ADDR_W] && lat_E != '0)));
      forward[2*s +: 2] = (RegWrite_M && Waddr_M != '0 && Raddr_E[s*ADDR_W +: ADDR_W] == Waddr_M) ? 2'b10 :
                          (RegWrite_W && Waddr_W != '0 && Raddr_E[s*ADDR_W +: ADDR_W] == Waddr_W) ? 2'b01 : 2'b00;
    end
  end
  assign bubble_E = stall_D;
  assign busy     = |nz;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf;
  always_ff @(posedge clk)
    if (rst) perf <= '0;
    else if (stall_D && !hold && perf != '1) perf <= perf + 32'd1;
  assign stall_cycles = perf;
`else
  assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vector table plus multi-cycle stall sequences for hazard_forward_unit.
module tb_hazard_forward_unit;
  logic        clk = 1'b0, rst = 1'b1, hold = 1'b0;
  logic [9:0]  raddr_d = '0, raddr_e = '0;
  logic [1:0]  rused_d = '0;
  logic        issue_e = 1'b0, rw_m = 1'b0, rw_w = 1'b0;
  logic [4:0]  waddr_e = '0, waddr_m = '0, waddr_w = '0;
  logic [2:0]  lat_e = '0;
  logic [3:0]  forward;
  logic        stall_d, bubble_e, busy;
  logic [31:0] stall_cycles;
  int checks = 0, failures = 0;
  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .hold(hold), .Raddr_D(raddr_d), .Rused_D(rused_d), .Raddr_E(raddr_e),
    .issue_E(issue_e), .Waddr_E(waddr_e), .lat_E(lat_e), .Waddr_M(waddr_m), .RegWrite_M(rw_m),
    .Waddr_W(waddr_w), .RegWrite_W(rw_w), .forward(forward), .stall_D(stall_d), .bubble_E(bubble_e),
    .busy(busy), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0] rd; logic [1:0] ru; logic is; logic [4:0] we; logic [2:0] lt;
    logic [9:0] re; logic [4:0] wm; logic rm; logic [4:0] ww; logic rw;
    logic [3:0] fwd; logic stl;
  } vec_t;
  vec_t v [11];
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_multi(input int hc, output logic [15:0] sm, output logic [15:0] bm, output bit bad);
    issue_e = 1'b1; waddr_e = 5'd9; lat_e = 3'd3; raddr_d = {5'd0, 5'd9}; rused_d = 2'b01; hold = 1'b0;
    sm = '0; bm = '0; bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      sm[i] = stall_d; bm[i] = busy;
      if (bubble_e !== stall_d) bad = 1'b1;
      step();
      issue_e = 1'b0; hold = (i < hc);
    end
    hold = 1'b0; rused_d = '0;
  endtask
  initial begin
    logic [15:0] sm, bm;
    bit bad;
    int n;
    //        rd                 ru     is    we     lt    re                  wm     rm    ww     rw    fwd      stl
    v[0]  = '{{5'd0, 5'd0},  2'b00, 1'b0, 5'd0, 3'd0, {5'd5, 5'd5},   5'd5, 1'b1, 5'd5, 1'b1, 4'b1010, 1'b0};
    v[1]  = '{{5'd0, 5'd0},  2'b00, 1'b0, 5'd0, 3'd0, {5'd5, 5'd5},   5'd5, 1'b0, 5'd5, 1'b1, 4'b0101, 1'b0};
    v[2]  = '{{5'd0, 5'd0},  2'b00, 1'b0, 5'd0, 3'd0, {5'd0, 5'd0},   5'd0, 1'b1, 5'd0, 1'b1, 4'b0000, 1'b0};
    v[3]  = '{{5'd0, 5'd0},  2'b00, 1'b0, 5'd0, 3'd0, {5'd3, 5'd5},   5'd5, 1'b1, 5'd3, 1'b1, 4'b0110, 1'b0};
    v[4]  = '{{5'd0, 5'd0},  2'b00, 1'b0, 5'd0, 3'd0, {5'd6, 5'd6},   5'd6, 1'b0, 5'd7, 1'b1, 4'b0000, 1'b0};
    v[5]  = '{{5'd0, 5'd7},  2'b01, 1'b1, 5'd7, 3'd1, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b1};
    v[6]  = '{{5'd0, 5'd7},  2'b00, 1'b1, 5'd7, 3'd1, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b0};
    v[7]  = '{{5'd0, 5'd7},  2'b01, 1'b1, 5'd7, 3'd0, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b0};
    v[8]  = '{{5'd7, 5'd0},  2'b10, 1'b1, 5'd7, 3'd2, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b1};
    v[9]  = '{{5'd0, 5'd0},  2'b01, 1'b1, 5'd0, 3'd3, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b0};
    v[10] = '{{5'd0, 5'd7},  2'b01, 1'b1, 5'd8, 3'd1, {5'd7, 5'd7},   5'd7, 1'b1, 5'd0, 1'b1, 4'b1010, 1'b0};
    step(); step();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_perf", stall_cycles, 0);
    hold = 1'b1;
    for (int i = 0; i < 11; i++) begin
      raddr_d = v[i].rd; rused_d = v[i].ru; issue_e = v[i].is; waddr_e = v[i].we; lat_e = v[i].lt;
      raddr_e = v[i].re; waddr_m = v[i].wm; rw_m = v[i].rm; waddr_w = v[i].ww; rw_w = v[i].rw;
      #1;
      chk($sformatf("vec%0d_forward", i), forward, v[i].fwd);
      chk($sformatf("vec%0d_stall", i), stall_d, v[i].stl);
      chk($sformatf("vec%0d_bubble", i), bubble_e, v[i].stl);
    end
    step();
    chk("hold_ignores_issue", busy, 0);
    hold = 1'b0; issue_e = 1'b0; rused_d = '0; rw_m = 1'b0; rw_w = 1'b0; raddr_e = '0;
    issue_e = 1'b1; waddr_e = 5'd9; lat_e = 3'd7;
    step();
    issue_e = 1'b0;
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; raddr_d = {5'd0, 5'd9}; rused_d = 2'b01;
    #1;
    chk("mid_op_reset_busy", busy, 0);
    chk("mid_op_reset_stall", stall_d, 0);
    chk("mid_op_reset_perf", stall_cycles, 0);
    rused_d = '0;
    run_multi(0, sm, bm, bad);
    chk("multi_stall_mask", sm, 16'h0007);
    chk("multi_busy_mask", bm, 16'h000E);
    chk("multi_bubble_eq", bad, 0);
    chk("multi_perf", stall_cycles, PERF ? 3 : 0);
    run_multi(2, sm, bm, bad);
    chk("hold_stall_mask", sm, 16'h001F);
    chk("hold_busy_mask", bm, 16'h003E);
    chk("hold_perf", stall_cycles, PERF ? 6 : 0);
    issue_e = 1'b1; waddr_e = 5'd7; lat_e = 3'd1; raddr_d = {5'd0, 5'd7}; rused_d = 2'b01;
    #1;
    chk("loaduse_stall0", stall_d, 1);
    step();
    issue_e = 1'b0;
    #1;
    chk("loaduse_stall1", stall_d, 0);
    chk("loaduse_busy1", busy, 1);
    step();
    chk("loaduse_busy2", busy, 0);
    rused_d = '0;
    issue_e = 1'b1; waddr_e = 5'd4; lat_e = 3'd5;
    step();
    lat_e = 3'd1;
    step();
    issue_e = 1'b0; raddr_d = {5'd4, 5'd0}; rused_d = 2'b10;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n += int'(stall_d);
      step();
    end
    chk("waw_stall_count", n, 3);
    chk("saturate_busy", busy, 0);
    chk("final_perf", stall_cycles, PERF ? 10 : 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
